// File: rtl/medidor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | medidor_pkg: states and default constants for the measurement       |
// | sequencer.                              Rev 1.0                      |
// +----------------------------------------------------------------------+
package medidor_pkg;

  localparam int OUT_WIDTH_DEF   = 32;
  localparam int SEL_WIDTH_DEF   = 8;
  localparam int SETTLE_DEF      = 16;
  localparam int CLR_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_CLEAR   = 3'd4
  } estado_t;

  // The counter is loaded with (cycles - 1), so clog2 of the larger wait suffices.
  function automatic int ancho_contador(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_espera.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_espera: loadable down-counter shared by the settle and      |
// | clear-timeout waits.                    Rev 1.0                      |
// +----------------------------------------------------------------------+
module contador_espera #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/secuenciador_medidas.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | secuenciador_medidas: sweeps an oscillator mux through an external  |
// | frequency meter and streams one count per oscillator.  Rev 1.0       |
// +----------------------------------------------------------------------+
module secuenciador_medidas
  import medidor_pkg::*;
#(
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SEL_WIDTH   = SEL_WIDTH_DEF,
  parameter int SETTLE      = SETTLE_DEF,
  parameter int CLR_TIMEOUT = CLR_TIMEOUT_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] n_osc,
  input  logic [4:0]           resol_in,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 meas_enable,
  output logic [4:0]           meas_resol,
  input  logic                 meas_lock,
  input  logic [OUT_WIDTH-1:0] meas_out,
  output logic [OUT_WIDTH-1:0] data,
  output logic [SEL_WIDTH-1:0] data_idx,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int CNT_W = ancho_contador(SETTLE, CLR_TIMEOUT);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD    = CNT_W'(CLR_TIMEOUT - 1);

  estado_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]   idx_q, idx_d;
  logic [SEL_WIDTH-1:0]   n_osc_q, n_osc_d;
  logic [4:0]             resol_q, resol_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;
  logic [SEL_WIDTH-1:0]   data_idx_q, data_idx_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;

  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_load_val;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic [SEL_WIDTH-1:0]   last_idx;

  assign last_idx = n_osc_q - SEL_WIDTH'(1);

  contador_espera #(
    .WIDTH (CNT_W)
  ) u_espera (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_osc_d      = n_osc_q;
    resol_d      = resol_q;
    data_d       = data_q;
    data_idx_d   = data_idx_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    cnt_load     = 1'b0;
    cnt_load_val = SETTLE_LOAD;
    cnt_dec      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_osc == '0) begin
            done_d = 1'b1;
          end else begin
            n_osc_d   = n_osc;
            resol_d   = resol_in;
            idx_d     = '0;
            timeout_d = 1'b0;
            cnt_load  = 1'b1;
            state_d   = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) state_d = ST_MEASURE;
        else          cnt_dec = 1'b1;
      end
      ST_MEASURE: begin
        // The meter keeps counting while locked: only the first lock cycle is valid.
        if (meas_lock) begin
          data_d     = meas_out;
          data_idx_d = idx_q;
          state_d    = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (data_ready) begin
          cnt_load     = 1'b1;
          cnt_load_val = CLR_LOAD;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (!meas_lock || cnt_zero) begin
          if (meas_lock) timeout_d = 1'b1;
          if (idx_q == last_idx) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d    = idx_q + SEL_WIDTH'(1);
            cnt_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      n_osc_q    <= '0;
      resol_q    <= '0;
      data_q     <= '0;
      data_idx_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_osc_q    <= n_osc_d;
      resol_q    <= resol_d;
      data_q     <= data_d;
      data_idx_q <= data_idx_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // idx only moves on entry to SETTLE, so it doubles as the mux select.
  assign sel         = idx_q;
  assign meas_enable = (state_q == ST_MEASURE);
  assign data_valid  = (state_q == ST_OUTPUT);
  assign busy        = (state_q != ST_IDLE);
  assign meas_resol  = resol_q;
  assign data        = data_q;
  assign data_idx    = data_idx_q;
  assign done        = done_q;
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_medidas.sv
`default_nettype none
// Testbench for secuenciador_medidas: table-driven and random sweeps against a
// meter model and a result scoreboard.
module tb_secuenciador_medidas;

  localparam int OUT_W    = 32;
  localparam int SEL_W    = 8;
  localparam int SETTLE_T = 4;
  localparam int CLR_T    = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [SEL_W-1:0] n_osc = '0;
  logic [4:0]       resol_in = '0;
  logic [SEL_W-1:0] sel;
  logic             meas_enable;
  logic [4:0]       meas_resol;
  logic             meas_lock = 1'b0;
  logic [OUT_W-1:0] meas_out = '0;
  logic [OUT_W-1:0] data;
  logic [SEL_W-1:0] data_idx;
  logic             data_valid;
  logic             data_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             timeout_err;

  secuenciador_medidas #(
    .OUT_WIDTH   (OUT_W),
    .SEL_WIDTH   (SEL_W),
    .SETTLE      (SETTLE_T),
    .CLR_TIMEOUT (CLR_T)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .n_osc       (n_osc),
    .resol_in    (resol_in),
    .sel         (sel),
    .meas_enable (meas_enable),
    .meas_resol  (meas_resol),
    .meas_lock   (meas_lock),
    .meas_out    (meas_out),
    .data        (data),
    .data_idx    (data_idx),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [SEL_W-1:0] idx;
  } res_t;

  typedef struct {
    int n;
    int resol;
    int stall;
    int ready_pct;
    int mid_start;
    int stuck;
    int exp_results;
    int exp_timeout;
  } vec_t;

  res_t exp_q[$];
  int   hs_at[$];
  int   checks = 0;
  int   errors = 0;
  int   res_count = 0;
  int   force_stall = 0;
  int   ready_pct = 0;
  int   ncyc = 0;
  int   to_rise = -1;
  int   exp_resol = 0;
  bit   stuck = 1'b0;
  bit   prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0, prev_to = 1'b0;
  int   lat_cnt = 0, lat_target = 0, rel_cnt = 0, rel_target = 0;

  // Meter reading for oscillator i at resolution r: fixed frequency ratio scaled by 2^r.
  function automatic logic [OUT_W-1:0] meter_count(input int i, input int r);
    logic [OUT_W-1:0] one;
    one = 1;
    return (one << r) * OUT_W'(100 + 3 * i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},        64'(busy), 0);
    chk({tag, "_done"},        64'(done), 0);
    chk({tag, "_data_valid"},  64'(data_valid), 0);
    chk({tag, "_meas_enable"}, 64'(meas_enable), 0);
    chk({tag, "_sel"},         64'(sel), 0);
    chk({tag, "_data"},        64'(data), 0);
    chk({tag, "_data_idx"},    64'(data_idx), 0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 0);
    chk({tag, "_meas_resol"},  64'(meas_resol), 0);
  endtask

  // Single negedge process: drive data_ready, score results, then model the meter.
  always @(negedge clock) begin
    ncyc++;
    if (!reset_n) begin
      data_ready = 1'b0;
      meas_lock  = 1'b0;
      meas_out   = '0;
      lat_cnt    = 0;
      rel_cnt    = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_done  = 1'b0;
      prev_to    = 1'b0;
    end else begin
      if (data_valid && force_stall > 0) begin
        data_ready = 1'b0;
        force_stall--;
      end else begin
        data_ready = ($urandom_range(0, 99) >= ready_pct);
      end

      if (prev_valid && !prev_ready) chk("valid_held", 64'(data_valid), 1);
      if (data_valid) begin
        chk("enable_low_in_output", 64'(meas_enable), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(data_valid), 0);
        end else begin
          chk("data", 64'(data), 64'(exp_q[0].data));
          chk("data_idx", 64'(data_idx), 64'(exp_q[0].idx));
          if (data_ready) begin
            void'(exp_q.pop_front());
            res_count++;
            hs_at.push_back(ncyc);
          end
        end
      end
      if (busy) chk("meas_resol", 64'(meas_resol), 64'(exp_resol));
      if (done) begin
        chk("done_single_cycle", 64'(prev_done), 0);
        chk("done_all_results", 64'(exp_q.size()), 0);
      end
      if (timeout_err && !prev_to) to_rise = ncyc;
      prev_valid = data_valid;
      prev_ready = data_ready;
      prev_done  = done;
      prev_to    = timeout_err;

      if (stuck) rel_target = 0;
      if (meas_enable) begin
        rel_cnt = 0;
        if (!meas_lock) begin
          if (lat_cnt >= lat_target) begin
            meas_lock = 1'b1;
            meas_out  = meter_count(int'(sel), int'(meas_resol));
          end else begin
            lat_cnt++;
          end
        end else begin
          meas_out = meas_out + 1;
        end
      end else begin
        lat_cnt    = 0;
        lat_target = $urandom_range(0, 5);
        if (meas_lock) begin
          meas_out = meas_out + 1;
          if (!(stuck && !timeout_err)) begin
            if (rel_cnt >= rel_target) begin
              meas_lock  = 1'b0;
              rel_cnt    = 0;
              rel_target = $urandom_range(0, 3);
            end else begin
              rel_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic run_sweep(input vec_t v);
    res_t r;
    bit   got;
    exp_q.delete();
    hs_at.delete();
    to_rise   = -1;
    res_count = 0;
    for (int i = 0; i < v.n; i++) begin
      r.data = meter_count(i, v.resol);
      r.idx  = SEL_W'(i);
      exp_q.push_back(r);
    end
    exp_resol   = v.resol;
    force_stall = v.stall;
    ready_pct   = v.ready_pct;
    stuck       = (v.stuck != 0);
    @(negedge clock);
    start    = 1'b1;
    n_osc    = SEL_W'(v.n);
    resol_in = 5'(v.resol);
    @(negedge clock);
    start    = 1'b0;
    n_osc    = SEL_W'($urandom);
    resol_in = 5'($urandom);
    got = 1'b0;
    for (int k = 0; k < v.n * 300 + 300 && !got; k++) begin
      @(negedge clock);
      if (done) begin
        got   = 1'b1;
        start = 1'b0;
      end else if (v.mid_start != 0 && k == 8) begin
        start    = 1'b1;
        n_osc    = SEL_W'(v.n + 4);
        resol_in = 5'(v.resol + 7);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("sweep_done_seen", 64'(got), 1);
    @(negedge clock);
    #1;
    chk("busy_after_done", 64'(busy), 0);
    chk("done_pulse_ended", 64'(done), 0);
    chk("result_count", 64'(res_count), 64'(v.exp_results));
    chk("timeout_err", 64'(timeout_err), 64'(v.exp_timeout));
    if (v.stuck != 0) chk("timeout_latency", 64'(to_rise - hs_at[0]), 9);
    stuck = 1'b0;
  endtask

  vec_t tbl[7];
  vec_t rv;
  res_t rr;
  bit   got_m;

  initial begin
    //           n   res stall rdy% mid stuck exp_res exp_to
    tbl[0] = '{  3,   4,   0,   0,   0,  0,    3,     0};
    tbl[1] = '{  3,   4,  50,   0,   0,  0,    3,     0};
    tbl[2] = '{  2,   3,   0,   0,   0,  1,    2,     1};
    tbl[3] = '{  4,  12,   0,  30,   0,  0,    4,     0};
    tbl[4] = '{  3,   5,   0,   0,   1,  0,    3,     0};
    tbl[5] = '{  1,   0,   0,  50,   0,  0,    1,     0};
    tbl[6] = '{255,  31,   0,   0,   0,  0,  255,     0};

    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clock);

    foreach (tbl[i]) run_sweep(tbl[i]);

    // Zero oscillators: done pulse only, never busy.
    exp_q.delete();
    @(negedge clock);
    start = 1'b1;
    n_osc = '0;
    @(negedge clock);
    start = 1'b0;
    chk("zero_osc_done", 64'(done), 1);
    chk("zero_osc_busy", 64'(busy), 0);
    @(negedge clock);
    chk("zero_osc_done_end", 64'(done), 0);
    chk("zero_osc_busy_end", 64'(busy), 0);

    // Asynchronous reset while measuring oscillator 1.
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      rr.data = meter_count(i, 9);
      rr.idx  = SEL_W'(i);
      exp_q.push_back(rr);
    end
    exp_resol   = 9;
    ready_pct   = 0;
    force_stall = 0;
    @(negedge clock);
    start    = 1'b1;
    n_osc    = 3;
    resol_in = 9;
    @(negedge clock);
    start = 1'b0;
    got_m = 1'b0;
    for (int k = 0; k < 400 && !got_m; k++) begin
      @(negedge clock);
      if (meas_enable && sel == 1) got_m = 1'b1;
    end
    chk("reached_measure_idx1", 64'(got_m), 1);
    #3 reset_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    exp_q.delete();
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clock);
    rv = '{2, 2, 0, 0, 0, 0, 2, 0};
    run_sweep(rv);

    // Random sweeps.
    for (int r = 0; r < 12; r++) begin
      rv.n           = $urandom_range(1, 6);
      rv.resol       = $urandom_range(0, 31);
      rv.stall       = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
      rv.ready_pct   = $urandom_range(0, 60);
      rv.mid_start   = (rv.n >= 3) ? $urandom_range(0, 1) : 0;
      rv.stuck       = 0;
      rv.exp_results = rv.n;
      rv.exp_timeout = 0;
      run_sweep(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/secuenciador_medidas.md
SECUENCIADOR_MEDIDAS -- requirements
Module: secuenciador_medidas

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 32: width of the count word read from the frequency meter.
REQ-002 SHALL have parameter SEL_WIDTH, default 8: width of the oscillator index and count.
REQ-003 SHALL have parameter SETTLE, default 16: clock cycles to wait after a select change before enabling the meter.
REQ-004 SHALL have parameter CLR_TIMEOUT, default 1024: maximum clock cycles to wait for meter lock to clear.
REQ-005 SHALL have port clock, input, 1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: begin a sweep; sampled only in IDLE.
REQ-008 SHALL have port n_osc, input, SEL_WIDTH: number of oscillators to sweep, indices 0..n_osc-1.
REQ-009 SHALL have port resol_in, input, 5: meter resolution exponent for the sweep.
REQ-010 SHALL have port sel, output, SEL_WIDTH: oscillator mux select.
REQ-011 SHALL have port meas_enable, output, 1: drives the meter enable.
REQ-012 SHALL have port meas_resol, output, 5: drives the meter resol.
REQ-013 SHALL have port meas_lock, input, 1: meter lock, synchronous to clock.
REQ-014 SHALL have port meas_out, input, OUT_WIDTH: meter count.
REQ-015 SHALL have ports data, data_idx, data_valid (outputs) and data_ready (input): result stream of OUT_WIDTH, SEL_WIDTH, 1 and 1 bits.
REQ-016 SHALL have ports busy, done and timeout_err, outputs, 1 bit each: sweep active; one-cycle end-of-sweep pulse; sticky clear-timeout flag.

Function
REQ-017 SHALL implement states IDLE, SETTLE, MEASURE, OUTPUT, CLEAR.
REQ-018 IDLE: on start=1, SHALL latch n_osc and resol_in, set idx=0 and go to SETTLE; if n_osc=0, SHALL instead pulse done for one cycle and stay in IDLE.
REQ-019 start while not in IDLE SHALL be ignored.
REQ-020 SETTLE: SHALL drive sel=idx and meas_enable=0, and count SETTLE cycles; it SHALL then go to MEASURE.
REQ-021 MEASURE: SHALL hold meas_enable=1; in the first cycle meas_lock=1, it SHALL capture meas_out into data and idx into data_idx, then go to OUTPUT with meas_enable=0 from the next cycle.
REQ-022 Capture SHALL occur exactly once per oscillator, on the first lock cycle, because the meter output keeps changing while lock is held.
REQ-023 OUTPUT: SHALL assert data_valid with data and data_idx stable until the cycle data_ready=1; it SHALL then deassert data_valid and go to CLEAR.
REQ-024 CLEAR: SHALL keep meas_enable=0 until meas_lock=0, then either increment idx and go to SETTLE, or, if idx=n_osc-1, pulse done and go to IDLE.
REQ-025 If CLEAR lasts CLR_TIMEOUT cycles, SHALL set timeout_err and proceed as if meas_lock=0; timeout_err clears only on the next accepted start.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 meas_resol SHALL equal the latched resol at all times.
REQ-028 sel SHALL change only on the transition into SETTLE.
REQ-029 idx SHALL never wrap: n_osc=2^SEL_WIDTH-1 sweeps indices 0..2^SEL_WIDTH-2.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE and set sel, idx, data, data_idx, data_valid, done, busy, meas_enable, timeout_err and the latched resol to 0, including mid-sweep; no partial result SHALL be emitted after reset.

Structure
REQ-031 State encoding and default parameter constants SHALL live in a shared package, medidor_pkg.
REQ-032 The settle/timeout down-counter SHALL be one sub-module, contador_espera, reused by SETTLE and CLEAR.
REQ-033 The meter SHALL stay external, connected via sel, meas_enable, meas_resol, meas_lock and meas_out.

Verification
REQ-034 n_osc=3, resol_in=4, data_ready=1, meter model at known ratios -> three results with data_idx 0,1,2, then one done pulse and busy=0.
REQ-035 data_ready held 0 for 50 cycles in OUTPUT -> data and data_valid stable, meas_enable=0 throughout.
REQ-036 start with n_osc=0 -> done pulse one cycle after start, busy never 1.
REQ-037 meas_lock stuck at 1 after capture, CLR_TIMEOUT=8 -> timeout_err=1 after 8 cycles, sweep continues to the next idx.
REQ-038 reset_n pulsed low during MEASURE of idx 1 -> all outputs 0 asynchronously; a new start restarts at idx 0.
REQ-039 start pulsed mid-sweep -> ignored; sweep completes with unchanged n_osc and resol.
